// File: rtl/tof_pkg.sv
// tof_pkg: shared defaults, result-word layout and collector state for the ToF result path
package tof_pkg;
  localparam int DEF_NB_OF_SENSORS = 8;
  localparam int DEF_DATA_W = 22;
  localparam int SNS_W = 3;
  localparam int RESULT_W = SNS_W + DEF_DATA_W;
  localparam int SNS_LSB = DEF_DATA_W;
  localparam int DIST_LSB = 0;
  localparam int DIST_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_CAPTURE, S_ACK, S_SETTLE} state_t;
endpackage

// File: rtl/tof_result_fifo.sv
// tof_result_fifo: single-clock FIFO with level output; storage is reset so the head reads zero
module tof_result_fifo #(
  parameter int W = 25,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_level;
  logic w_push, w_pop;
  assign o_empty = r_level == '0;
  assign o_full = r_level == (AW+1)'(DEPTH);
  // full/empty are judged at the start of the cycle, so a push while full is dropped even with a pop
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_dout = r_mem[r_rd];
  assign o_level = r_level;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/tof_result_collector.sv
// tof_result_collector: round-robin drains per-sensor ToF results into a tagged FIFO
module tof_result_collector
  import tof_pkg::*;
#(
  parameter int NB_OF_SENSORS = DEF_NB_OF_SENSORS,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NB_OF_SENSORS-1:0]      ready_in,
  input  logic [DATA_W-1:0]             data_in,
  output logic [2:0]                    tof_index,
  output logic                          index_valid,
  output logic [SNS_W+DATA_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt
);
  state_t r_state;
  logic [2:0] r_tof_index, r_rr;
  logic r_index_valid;
  logic [15:0] r_ovf;
  logic [NB_OF_SENSORS-1:0] w_rot;
  logic [3:0] w_off, w_sum;
  logic [2:0] w_pick;
  logic w_full, w_empty, w_push;
  // rotate so bit 0 is rr_ptr, find the lowest set offset, then rotate back
  always_comb begin
    w_rot = NB_OF_SENSORS'({ready_in, ready_in} >> r_rr);
    w_off = '0;
    for (int k = NB_OF_SENSORS-1; k >= 0; k--) w_off = w_rot[k] ? 4'(k) : w_off;
    w_sum = {1'b0, r_rr} + w_off;
    w_pick = 3'(w_sum >= 4'(NB_OF_SENSORS) ? w_sum - 4'(NB_OF_SENSORS) : w_sum);
  end
  assign w_push = r_state == S_CAPTURE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_rr <= '0;
      r_tof_index <= '0;
      r_index_valid <= 1'b0;
      r_ovf <= '0;
    end else begin
      r_index_valid <= r_state == S_CAPTURE;
      case (r_state)
        S_IDLE: if (|ready_in) begin
          r_tof_index <= w_pick;
          r_state <= S_SELECT;
        end
        S_SELECT: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_ovf <= (w_full && r_ovf != 16'hFFFF) ? r_ovf + 16'd1 : r_ovf;
          r_state <= S_ACK;
        end
        S_ACK: r_state <= S_SETTLE;
        S_SETTLE: begin
          r_rr <= (r_tof_index == 3'(NB_OF_SENSORS-1)) ? 3'd0 : r_tof_index + 3'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  tof_result_fifo #(.W(SNS_W+DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .i_push(w_push),
    .i_din({r_tof_index, data_in}),
    .i_pop(out_ready),
    .o_dout(out_data),
    .o_empty(w_empty),
    .o_full(w_full),
    .o_level(fifo_level)
  );
  assign tof_index = r_tof_index;
  assign index_valid = r_index_valid;
  assign out_valid = !w_empty;
  assign overflow_cnt = r_ovf;
endmodule

// File: tb/tb_tof_result_collector.sv
// tb_tof_result_collector: directed stimulus with a queue scoreboard checked by an output monitor
module tb_tof_result_collector;
  logic clk, reset, index_valid, out_valid, out_ready;
  logic [7:0] ready_in;
  logic [21:0] data_in;
  logic [2:0] tof_index;
  logic [24:0] out_data;
  logic [4:0] fifo_level;
  logic [15:0] overflow_cnt;
  logic [21:0] data_tab [8];
  logic [2:0] exp_ack [$];
  logic [24:0] exp_out [$];
  int n_checks = 0, n_fail = 0, cyc = 0, last_ack = 0;
  bit have_last = 0, chk_gap = 0, watch67 = 0, saw67 = 0;

  assign data_in = data_tab[tof_index];

  tof_result_collector dut (
    .clk(clk), .reset(reset), .ready_in(ready_in), .data_in(data_in),
    .tof_index(tof_index), .index_valid(index_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic expect_service(input logic [2:0] s);
    exp_ack.push_back(s);
    exp_out.push_back({s, data_tab[s]});
  endtask

  task automatic do_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic wait_acks(input int n, input bit clr);
    int got = 0;
    for (int c = 0; c < 10*n + 20 && got < n; c++) begin
      @(negedge clk);
      if (watch67 && tof_index >= 3'd6) saw67 = 1;
      if (index_valid) begin
        got++;
        if (clr) ready_in[tof_index] = 1'b0;
      end
    end
    if (got < n) fail_now("ack_timeout");
  endtask

  task automatic drain();
    int c = 0;
    out_ready = 1;
    while (out_valid && c < 64) begin
      @(negedge clk);
      c++;
    end
    check("drain_level", 32'(fifo_level), 0);
  endtask

  // monitor: samples just after the falling edge, i.e. the values the next rising edge will use
  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (reset) begin
      if (index_valid) begin
        if (exp_ack.size() == 0) fail_now("ack_unexpected");
        else check("ack_idx", 32'(tof_index), 32'(exp_ack.pop_front()));
        if (chk_gap) begin
          if (have_last) check("ack_gap", 32'(cyc - last_ack), 5);
          last_ack = cyc;
          have_last = 1;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) fail_now("pop_unexpected");
        else check("pop_data", 32'(out_data), 32'(exp_out.pop_front()));
      end
    end
  end

  initial begin
    reset = 0;
    ready_in = '0;
    out_ready = 0;
    for (int i = 0; i < 8; i++) data_tab[i] = {6'(i + 16), 16'(i * 1000 + 7)};
    data_tab[2] = 22'h0A0123;
    repeat (2) @(negedge clk);
    check("rst_idx", 32'(tof_index), 0);
    check("rst_iv", 32'(index_valid), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ovf", 32'(overflow_cnt), 0);
    check("rst_data", 32'(out_data), 0);
    reset = 1;
    // single source, sensor 2
    @(negedge clk);
    out_ready = 1;
    ready_in = 8'h04;
    expect_service(3'd2);
    @(negedge clk);
    check("t1_idx_c1", 32'(tof_index), 2);
    check("t1_iv_c1", 32'(index_valid), 0);
    @(negedge clk);
    check("t1_iv_c2", 32'(index_valid), 0);
    @(negedge clk);
    check("t1_iv_c3", 32'(index_valid), 1);
    check("t1_level_1", 32'(fifo_level), 1);
    check("t1_out_data", 32'(out_data), 32'({3'd2, 22'h0A0123}));
    ready_in = 8'h00;
    @(negedge clk);
    check("t1_level_0", 32'(fifo_level), 0);
    check("t1_iv_c4", 32'(index_valid), 0);
    repeat (2) @(negedge clk);
    // fairness between sensors 0 and 7 with flags held
    do_reset();
    out_ready = 1;
    have_last = 0;
    chk_gap = 1;
    for (int i = 0; i < 6; i++) expect_service(i % 2 == 1 ? 3'd7 : 3'd0);
    ready_in = 8'h81;
    wait_acks(6, 0);
    ready_in = 8'h00;
    repeat (4) @(negedge clk);
    chk_gap = 0;
    // wrap: serve 5 so rr_ptr=6, then sensors 0 and 1
    ready_in = 8'h20;
    expect_service(3'd5);
    wait_acks(1, 1);
    ready_in = 8'h03;
    expect_service(3'd0);
    expect_service(3'd1);
    saw67 = 0;
    watch67 = 1;
    wait_acks(2, 1);
    watch67 = 0;
    check("wrap_no67", 32'(saw67), 0);
    drain();
    // overflow: 20 services into a 16-deep FIFO
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 20; i++)
      if (i < 16) expect_service(3'(i));
      else exp_ack.push_back(3'(i));
    ready_in = 8'hFF;
    wait_acks(20, 0);
    ready_in = 8'h00;
    repeat (3) @(negedge clk);
    check("ovf_level", 32'(fifo_level), 16);
    check("ovf_cnt", 32'(overflow_cnt), 4);
    check("ovf_valid", 32'(out_valid), 1);
    drain();
    check("ovf_cnt_after", 32'(overflow_cnt), 4);
    // push and pop together at level 15
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 15; i++) expect_service(3'(i));
    ready_in = 8'hFF;
    wait_acks(15, 0);
    ready_in = 8'h00;
    repeat (3) @(negedge clk);
    check("l15_pre", 32'(fifo_level), 15);
    ready_in = 8'h80;
    expect_service(3'd7);
    @(negedge clk);
    @(negedge clk);
    check("l15_idx", 32'(tof_index), 7);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    ready_in = 8'h00;
    check("l15_level", 32'(fifo_level), 15);
    check("l15_ovf", 32'(overflow_cnt), 0);
    check("l15_iv", 32'(index_valid), 1);
    drain();
    // reset during CAPTURE of sensor 4
    do_reset();
    out_ready = 1;
    ready_in = 8'h10;
    @(negedge clk);
    check("mr_sel_idx", 32'(tof_index), 4);
    @(negedge clk);
    reset = 0;
    #1;
    check("mr_idx", 32'(tof_index), 0);
    check("mr_iv", 32'(index_valid), 0);
    check("mr_valid", 32'(out_valid), 0);
    check("mr_level", 32'(fifo_level), 0);
    check("mr_ovf", 32'(overflow_cnt), 0);
    check("mr_data", 32'(out_data), 0);
    @(negedge clk);
    check("mr_iv_hold", 32'(index_valid), 0);
    @(negedge clk);
    reset = 1;
    expect_service(3'd4);
    wait_acks(1, 1);
    drain();
    repeat (2) @(negedge clk);
    check("q_ack_empty", 32'(exp_ack.size()), 0);
    check("q_out_empty", 32'(exp_out.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
